// File: rtl/mem_stage.sv
// LC-3b memory stage: data-memory FSM with byte/word lane handling and LDI/STI pointer fetch.
// Define MEM_INDIRECT_EN to run LDI/STI as two back-to-back accesses inside this stage.

package lc3b_types;
  typedef logic [3:0] lc3b_opcode;
  typedef logic [2:0] lc3b_reg;

  localparam lc3b_opcode op_br   = 4'h0;
  localparam lc3b_opcode op_add  = 4'h1;
  localparam lc3b_opcode op_ldb  = 4'h2;
  localparam lc3b_opcode op_stb  = 4'h3;
  localparam lc3b_opcode op_jsr  = 4'h4;
  localparam lc3b_opcode op_and  = 4'h5;
  localparam lc3b_opcode op_ldr  = 4'h6;
  localparam lc3b_opcode op_str  = 4'h7;
  localparam lc3b_opcode op_rti  = 4'h8;
  localparam lc3b_opcode op_not  = 4'h9;
  localparam lc3b_opcode op_ldi  = 4'hA;
  localparam lc3b_opcode op_sti  = 4'hB;
  localparam lc3b_opcode op_jmp  = 4'hC;
  localparam lc3b_opcode op_shf  = 4'hD;
  localparam lc3b_opcode op_lea  = 4'hE;
  localparam lc3b_opcode op_trap = 4'hF;

  typedef struct packed {
    lc3b_opcode opcode;
    logic       mem_read;
    logic       mem_write;
    logic       load_regfile;
    logic       load_cc;
    logic       branch_stall;
  } lc3b_control_word;
endpackage

module mem_stage
  import lc3b_types::*;
(
  input  logic             clk,
  input  logic             reset,
  input  lc3b_control_word cw_in,
  input  logic             valid_in,
  input  logic [15:0]      address_in,
  input  logic [15:0]      result_in,
  input  logic [15:0]      store_data,
  input  lc3b_reg          dr_in,
  output logic [15:0]      dmem_address,
  output logic             dmem_read,
  output logic             dmem_write,
  output logic [1:0]       dmem_wmask,
  output logic [15:0]      dmem_wdata,
  input  logic [15:0]      dmem_rdata,
  input  logic             dmem_resp,
  output logic [15:0]      wb_data,
  output lc3b_reg          wb_dr,
  output logic             wb_load_regfile,
  output logic             wb_load_cc,
  output logic             mem_stall,
  output logic             mem_br_stall
);

`ifdef MEM_INDIRECT_EN
  localparam logic IND_EN = 1'b1;
`else
  localparam logic IND_EN = 1'b0;
`endif

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_IND_PTR = 2'd1;
  localparam logic [1:0] S_ACCESS  = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [15:0] ptr_q, ptr_d, ldata_q, ldata_d;
  logic        rd_q, rd_d, wr_q, wr_d, byte_q, byte_d, ind_q, ind_d;
  logic        settle_q;

  logic        is_ind_op_s, is_byte_op_s, split_ind_s, req_s, read_op_s;
  logic [15:0] eff_addr_s;
  logic [7:0]  byte_s;

  function automatic logic [1:0] byte_mask(input logic odd);
    return odd ? 2'b10 : 2'b01;
  endfunction

  // Without in-stage indirection LDI/STI become a plain pointer read handed back to execute.
  assign is_ind_op_s  = (cw_in.opcode == op_ldi) || (cw_in.opcode == op_sti);
  assign is_byte_op_s = (cw_in.opcode == op_ldb) || (cw_in.opcode == op_stb);
  assign split_ind_s  = is_ind_op_s & ~IND_EN;
  assign req_s        = valid_in & (cw_in.mem_read | cw_in.mem_write) & ~settle_q;
  assign read_op_s    = cw_in.mem_read | split_ind_s;
  assign eff_addr_s   = ind_q ? ptr_q : address_in;
  assign byte_s       = eff_addr_s[0] ? dmem_rdata[15:8] : dmem_rdata[7:0];

  // Next-state, pointer and load-data capture.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ldata_d = ldata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    byte_d  = byte_q;
    ind_d   = ind_q;
    case (state_q)
      S_IDLE: begin
        if (req_s) begin
          rd_d    = read_op_s;
          wr_d    = ~read_op_s;
          byte_d  = is_byte_op_s;
          ind_d   = is_ind_op_s & IND_EN;
          state_d = (is_ind_op_s & IND_EN) ? S_IND_PTR : S_ACCESS;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_IND_PTR: begin
        if (dmem_resp) begin
          ptr_d   = dmem_rdata;
          state_d = S_ACCESS;
        end else begin
          state_d = S_IND_PTR;
        end
      end
      S_ACCESS: begin
        if (dmem_resp) begin
          if (rd_q) begin
            ldata_d = byte_q ? {8'h00, byte_s} : dmem_rdata;
          end else begin
            ldata_d = ldata_q;
          end
          state_d = S_DONE;
        end else begin
          state_d = S_ACCESS;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Memory port drive; everything parks at zero outside the access states.
  always_comb begin
    dmem_address = 16'h0000;
    dmem_read    = 1'b0;
    dmem_write   = 1'b0;
    dmem_wmask   = 2'b00;
    dmem_wdata   = 16'h0000;
    case (state_q)
      S_IND_PTR: begin
        dmem_address = {address_in[15:1], 1'b0};
        dmem_read    = 1'b1;
      end
      S_ACCESS: begin
        dmem_address = {eff_addr_s[15:1], 1'b0};
        dmem_read    = rd_q;
        dmem_write   = wr_q & ~rd_q;
        dmem_wmask   = byte_q ? byte_mask(eff_addr_s[0]) : 2'b11;
        dmem_wdata   = byte_q ? {store_data[7:0], store_data[7:0]} : store_data;
      end
      default: begin
        dmem_address = 16'h0000;
      end
    endcase
  end

  assign mem_stall       = (state_q == S_IND_PTR) | (state_q == S_ACCESS) |
                           ((state_q == S_IDLE) & req_s);
  assign wb_data         = read_op_s ? ldata_q : result_in;
  assign wb_dr           = dr_in;
  assign wb_load_regfile = valid_in & cw_in.load_regfile & ~mem_stall & ~settle_q & ~split_ind_s;
  assign wb_load_cc      = valid_in & cw_in.load_cc & ~mem_stall & ~settle_q & ~split_ind_s;
  assign mem_br_stall    = valid_in & cw_in.branch_stall;

  // State registers; settle_q keeps the cycle after reset fully quiet.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= 16'h0000;
      ldata_q  <= 16'h0000;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      byte_q   <= 1'b0;
      ind_q    <= 1'b0;
      settle_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      ldata_q  <= ldata_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      byte_q   <= byte_d;
      ind_q    <= ind_d;
      settle_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, hand-built corner sequences and
// random instructions scored against a transaction-level model backed by a sparse memory.

module tb_mem_stage;
  import lc3b_types::*;

`ifdef MEM_INDIRECT_EN
  localparam bit IND = 1'b1;
`else
  localparam bit IND = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  lc3b_control_word cw_in;
  logic             valid_in;
  logic [15:0]      address_in, result_in, store_data;
  lc3b_reg          dr_in;
  logic [15:0]      dmem_address, dmem_wdata, dmem_rdata, wb_data;
  logic             dmem_read, dmem_write, dmem_resp;
  logic [1:0]       dmem_wmask;
  lc3b_reg          wb_dr;
  logic             wb_load_regfile, wb_load_cc, mem_stall, mem_br_stall;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .reset(reset), .cw_in(cw_in), .valid_in(valid_in),
    .address_in(address_in), .result_in(result_in), .store_data(store_data), .dr_in(dr_in),
    .dmem_address(dmem_address), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_resp(dmem_resp), .wb_data(wb_data), .wb_dr(wb_dr),
    .wb_load_regfile(wb_load_regfile), .wb_load_cc(wb_load_cc),
    .mem_stall(mem_stall), .mem_br_stall(mem_br_stall)
  );

  typedef struct packed {
    bit          timeout;
    int          n_acc;
    int          stall;
    logic [15:0] f_addr;
    logic        f_rd;
    logic [15:0] l_addr;
    logic        l_rd;
    bit          has_wr;
    logic [1:0]  w_mask;
    logic [15:0] w_data;
    logic [15:0] wb;
    logic        ld_rf;
    logic        ld_cc;
    logic        br;
    bit          unstable;
    bit          both;
    bit          dr_bad;
  } obs_t;

  typedef struct {
    lc3b_opcode  op;
    logic [15:0] addr, sd, res;
    int          lat;
    bit          pre;
    logic [15:0] pd;
    bit          is_mem;
    bit          is_wr;
    logic [15:0] e_addr;
    logic [1:0]  e_mask;
    logic [15:0] e_wdata, e_wb;
    int          e_stall;
    logic        e_ld_rf, e_ld_cc;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] bmem [logic [15:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    logic [15:0] w;
    w = {a[15:1], 1'b0};
    if (bmem.exists(w)) return bmem[w];
    return w ^ 16'h5A3C;
  endfunction

  task automatic mem_wr(input logic [15:0] a, input logic [1:0] m, input logic [15:0] d);
    logic [15:0] cur;
    cur = mem_rd(a);
    if (m[0]) cur[7:0] = d[7:0];
    if (m[1]) cur[15:8] = d[15:8];
    bmem[{a[15:1], 1'b0}] = cur;
  endtask

  function automatic lc3b_control_word cw_of(input lc3b_opcode op);
    lc3b_control_word c;
    c = '0;
    c.opcode       = op;
    c.mem_read     = (op == op_ldb) || (op == op_ldr) || (op == op_ldi);
    c.mem_write    = (op == op_stb) || (op == op_str) || (op == op_sti);
    c.load_regfile = (op == op_add) || (op == op_and) || (op == op_not) || (op == op_shf) ||
                     (op == op_lea) || (op == op_ldb) || (op == op_ldr) || (op == op_ldi);
    c.load_cc      = c.load_regfile && (op != op_lea);
    c.branch_stall = (op == op_br) || (op == op_jmp) || (op == op_jsr) ||
                     (op == op_trap) || (op == op_rti);
    return c;
  endfunction

  // Transaction-level expectation: which accesses happen, how long the stage stalls, what retires.
  function automatic obs_t model(input lc3b_opcode op, input logic [15:0] addr, sd, res,
                                 input int lat, input bit drop);
    obs_t e;
    lc3b_control_word c;
    logic [15:0] a0, ptr, p0, w;
    bit ind2, split;
    e     = '0;
    c     = cw_of(op);
    a0    = {addr[15:1], 1'b0};
    ind2  = IND && (op == op_ldi || op == op_sti);
    split = !IND && (op == op_ldi || op == op_sti);
    e.wb  = res;
    if (c.mem_read || c.mem_write) begin
      e.n_acc  = ind2 ? 2 : 1;
      e.stall  = 1 + e.n_acc * lat;
      e.f_addr = a0;
      e.f_rd   = c.mem_read || split || ind2;
      if (ind2) begin
        ptr      = mem_rd(a0);
        p0       = {ptr[15:1], 1'b0};
        e.l_addr = p0;
        e.l_rd   = (op == op_ldi);
        if (op == op_ldi) e.wb = mem_rd(p0);
        else begin
          e.has_wr = 1'b1; e.w_mask = 2'b11; e.w_data = sd;
        end
      end else if (c.mem_read || split) begin
        w        = mem_rd(a0);
        e.wb     = (op == op_ldb) ? {8'h00, (addr[0] ? w[15:8] : w[7:0])} : w;
        e.l_addr = a0;
        e.l_rd   = 1'b1;
      end else begin
        e.l_addr = a0;
        e.has_wr = 1'b1;
        e.w_mask = (op == op_stb) ? (addr[0] ? 2'b10 : 2'b01) : 2'b11;
        e.w_data = (op == op_stb) ? {sd[7:0], sd[7:0]} : sd;
      end
    end
    e.ld_rf = !drop && c.load_regfile && !split;
    e.ld_cc = !drop && c.load_cc && !split;
    e.br    = !drop && c.branch_stall;
    return e;
  endfunction

  // Issue one instruction and act as the data memory until the stage stops stalling.
  task automatic run_instr(input lc3b_opcode op, input logic [15:0] addr, sd, res,
                           input int lat, input bit drop, output obs_t o);
    bit in_acc, fin;
    int acc_cyc;
    logic [15:0] a_addr, a_wd;
    logic [1:0] a_mk;
    logic a_rd, a_wr;
    o = '0; in_acc = 0; fin = 0; acc_cyc = 0;
    a_addr = '0; a_wd = '0; a_mk = '0; a_rd = 0; a_wr = 0;
    @(negedge clk);
    valid_in = 1'b1; cw_in = cw_of(op); address_in = addr; store_data = sd;
    result_in = res; dr_in = addr[2:0] ^ 3'b101;
    for (int c = 0; c < 200 && !fin; c++) begin
      if (c > 0) @(negedge clk);
      dmem_resp = 1'b0;
      #1;
      if (dmem_read && dmem_write) o.both = 1'b1;
      if (dmem_read || dmem_write) begin
        if (!in_acc) begin
          in_acc = 1; acc_cyc = 0; o.n_acc++;
          a_addr = dmem_address; a_rd = dmem_read; a_wr = dmem_write;
          a_mk = dmem_wmask; a_wd = dmem_wdata;
          if (o.n_acc == 1) begin o.f_addr = a_addr; o.f_rd = a_rd; end
          o.l_addr = a_addr; o.l_rd = a_rd;
          if (a_wr) begin o.has_wr = 1'b1; o.w_mask = a_mk; o.w_data = a_wd; end
        end else if (dmem_address !== a_addr || dmem_read !== a_rd || dmem_write !== a_wr ||
                     (a_wr && (dmem_wmask !== a_mk || dmem_wdata !== a_wd))) begin
          o.unstable = 1'b1;
        end
        acc_cyc++;
        if (acc_cyc >= lat) begin
          dmem_resp = 1'b1; in_acc = 0;
          if (dmem_read) dmem_rdata = mem_rd(dmem_address);
          else mem_wr(dmem_address, dmem_wmask, dmem_wdata);
        end
        if (drop && o.n_acc == 1 && acc_cyc == 1) valid_in = 1'b0;
      end
      if (mem_stall === 1'b1) o.stall++;
      else begin
        o.wb = wb_data; o.ld_rf = wb_load_regfile; o.ld_cc = wb_load_cc;
        o.br = mem_br_stall; o.dr_bad = (wb_dr !== dr_in); fin = 1;
      end
    end
    o.timeout = !fin;
  endtask

  task automatic check_obs(input string tag, input obs_t o, input obs_t e);
    chk({tag, " timeout"}, 32'(o.timeout), 32'(e.timeout));
    chk({tag, " accesses"}, 32'(o.n_acc), 32'(e.n_acc));
    chk({tag, " stall_cycles"}, 32'(o.stall), 32'(e.stall));
    chk({tag, " wb_data"}, 32'(o.wb), 32'(e.wb));
    chk({tag, " wb_load_regfile"}, 32'(o.ld_rf), 32'(e.ld_rf));
    chk({tag, " wb_load_cc"}, 32'(o.ld_cc), 32'(e.ld_cc));
    chk({tag, " mem_br_stall"}, 32'(o.br), 32'(e.br));
    chk({tag, " protocol(unstable,rd&wr,wb_dr)"}, 32'({o.unstable, o.both, o.dr_bad}), 32'(0));
    chk({tag, " write_seen"}, 32'(o.has_wr), 32'(e.has_wr));
    if (e.n_acc > 0) begin
      chk({tag, " first_addr"}, 32'(o.f_addr), 32'(e.f_addr));
      chk({tag, " first_is_read"}, 32'(o.f_rd), 32'(e.f_rd));
      chk({tag, " last_addr"}, 32'(o.l_addr), 32'(e.l_addr));
      chk({tag, " last_is_read"}, 32'(o.l_rd), 32'(e.l_rd));
    end
    if (e.has_wr) begin
      chk({tag, " wmask"}, 32'(o.w_mask), 32'(e.w_mask));
      chk({tag, " wdata"}, 32'(o.w_data), 32'(e.w_data));
    end
  endtask

  initial begin
    vec_t vt [8];
    obs_t o, e;
    lc3b_opcode ops [10];
    lc3b_opcode op;
    bit drop;

    reset = 1'b1; valid_in = 1'b0; cw_in = '0; address_in = '0; result_in = '0;
    store_data = '0; dr_in = '0; dmem_rdata = '0; dmem_resp = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset mem_stall", 32'(mem_stall), 32'(0));
    chk("reset dmem_rd_wr", 32'({dmem_read, dmem_write}), 32'(0));
    chk("reset dmem_addr_mask_wdata", 32'({dmem_address, dmem_wmask}) | 32'(dmem_wdata), 32'(0));
    chk("reset wb_loads", 32'({wb_load_regfile, wb_load_cc}), 32'(0));

    //        op      addr      sd        res      lat pre pd       mem wr e_addr    mask   wdata     wb       stall rf cc
    vt[0] = '{op_ldr, 16'h1234, 16'h0000, 16'h0101, 3, 1, 16'hBEEF, 1, 0, 16'h1234, 2'b00, 16'h0000, 16'hBEEF, 4, 1, 1};
    vt[1] = '{op_stb, 16'h2001, 16'h00A5, 16'h0202, 1, 0, 16'h0000, 1, 1, 16'h2000, 2'b10, 16'hA5A5, 16'h0202, 2, 0, 0};
    vt[2] = '{op_ldb, 16'h3000, 16'h0000, 16'h0303, 2, 1, 16'h7F80, 1, 0, 16'h3000, 2'b00, 16'h0000, 16'h0080, 3, 1, 1};
    vt[3] = '{op_add, 16'h0000, 16'h0000, 16'h0007, 1, 0, 16'h0000, 0, 0, 16'h0000, 2'b00, 16'h0000, 16'h0007, 0, 1, 1};
    vt[4] = '{op_ldb, 16'h3001, 16'h0000, 16'h0404, 1, 1, 16'h7F80, 1, 0, 16'h3000, 2'b00, 16'h0000, 16'h007F, 2, 1, 1};
    vt[5] = '{op_str, 16'h4567, 16'hBEEF, 16'h0505, 2, 0, 16'h0000, 1, 1, 16'h4566, 2'b11, 16'hBEEF, 16'h0505, 3, 0, 0};
    vt[6] = '{op_stb, 16'h2000, 16'h1234, 16'h0606, 4, 0, 16'h0000, 1, 1, 16'h2000, 2'b01, 16'h3434, 16'h0606, 5, 0, 0};
    vt[7] = '{op_ldr, 16'h2000, 16'h0000, 16'h0707, 1, 0, 16'h0000, 1, 0, 16'h2000, 2'b00, 16'h0000, 16'hA534, 2, 1, 1};

    for (int i = 0; i < 8; i++) begin
      if (vt[i].pre) bmem[vt[i].e_addr] = vt[i].pd;
      e = '0;
      e.n_acc = vt[i].is_mem ? 1 : 0;
      e.stall = vt[i].e_stall;
      e.f_addr = vt[i].e_addr; e.l_addr = vt[i].e_addr;
      e.f_rd = !vt[i].is_wr; e.l_rd = !vt[i].is_wr;
      e.has_wr = vt[i].is_wr; e.w_mask = vt[i].e_mask; e.w_data = vt[i].e_wdata;
      e.wb = vt[i].e_wb; e.ld_rf = vt[i].e_ld_rf; e.ld_cc = vt[i].e_ld_cc;
      run_instr(vt[i].op, vt[i].addr, vt[i].sd, vt[i].res, vt[i].lat, 1'b0, o);
      check_obs($sformatf("vec%0d", i), o, e);
    end

    // LDI: pointer at 4000 -> 5002, data 0042
    bmem[16'h4000] = 16'h5002; bmem[16'h5002] = 16'h0042;
    e = '0;
    e.f_addr = 16'h4000; e.f_rd = 1'b1; e.l_rd = 1'b1;
    if (IND) begin
      e.n_acc = 2; e.stall = 3; e.l_addr = 16'h5002; e.wb = 16'h0042; e.ld_rf = 1; e.ld_cc = 1;
    end else begin
      e.n_acc = 1; e.stall = 2; e.l_addr = 16'h4000; e.wb = 16'h5002;
    end
    run_instr(op_ldi, 16'h4000, 16'h0000, 16'h0808, 1, 1'b0, o);
    check_obs("ldi", o, e);

    // ADD with spurious responses in IDLE
    @(negedge clk);
    valid_in = 1'b1; cw_in = cw_of(op_add); result_in = 16'h0007; dmem_resp = 1'b1;
    #1;
    chk("add mem_stall", 32'(mem_stall), 32'(0));
    chk("add dmem_rd_wr", 32'({dmem_read, dmem_write}), 32'(0));
    chk("add wb_data", 32'(wb_data), 32'h0007);
    @(negedge clk);
    valid_in = 1'b0; cw_in = '0; dmem_resp = 1'b1;
    #1;
    chk("spurious mem_stall", 32'(mem_stall), 32'(0));
    @(negedge clk);
    dmem_resp = 1'b0;
    #1;
    chk("spurious dmem_read", 32'(dmem_read), 32'(0));

    // Reset in the middle of an LDR whose response never comes
    @(negedge clk);
    valid_in = 1'b1; cw_in = cw_of(op_ldr); address_in = 16'h1234;
    @(negedge clk);
    #1;
    chk("rstmid in_access", 32'(dmem_read), 32'(1));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rstmid mem_stall", 32'(mem_stall), 32'(0));
    chk("rstmid dmem_read", 32'(dmem_read), 32'(0));
    chk("rstmid wb_load_regfile", 32'(wb_load_regfile), 32'(0));
    valid_in = 1'b0;
    @(negedge clk);
    #1;
    chk("rstmid idle_after", 32'({mem_stall, dmem_read}), 32'(0));

    ops = '{op_add, op_and, op_ldb, op_stb, op_ldr, op_str, op_ldi, op_sti, op_br, op_lea};
    for (int n = 0; n < 40; n++) begin
      logic [15:0] ra, rs, rr;
      int lat;
      lc3b_control_word c;
      op  = ops[$urandom_range(0, 9)];
      ra  = 16'($urandom_range(0, 63));
      rs  = 16'($urandom);
      rr  = 16'($urandom);
      lat = $urandom_range(1, 4);
      c   = cw_of(op);
      drop = (c.mem_read || c.mem_write) && ($urandom_range(0, 5) == 0);
      e = model(op, ra, rs, rr, lat, drop);
      run_instr(op, ra, rs, rr, lat, drop, o);
      check_obs($sformatf("rand%0d op%0h", n, op), o, e);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports `clk` (input, 1): sole clock; all state updates on its rising edge.
REQ-002 SHALL have port `reset` (input, 1): synchronous, active-high reset.
REQ-003 SHALL have port `cw_in` (input, lc3b_control_word): control word latched from the execute stage.
REQ-004 SHALL have port `valid_in` (input, 1): the instruction in this stage is live.
REQ-005 SHALL have ports `address_in` and `result_in` (input, 16 each): effective address and ALU result from the execute stage.
REQ-006 SHALL have ports `store_data` (input, 16) and `dr_in` (input, lc3b_reg): source register value for stores, and destination register.
REQ-007 SHALL have ports `dmem_address` (output, 16), `dmem_read` (output, 1), `dmem_write` (output, 1), `dmem_wmask` (output, 2) and `dmem_wdata` (output, 16).
REQ-008 SHALL have ports `dmem_rdata` (input, 16) and `dmem_resp` (input, 1): one-cycle response pulse.
REQ-009 SHALL have ports `wb_data` (output, 16), `wb_dr` (output, lc3b_reg), `wb_load_regfile` (output, 1) and `wb_load_cc` (output, 1).
REQ-010 SHALL have ports `mem_stall` (output, 1): freeze upstream stages; and `mem_br_stall` (output, 1): control transfer resolving here.

Function
REQ-011 SHALL implement FSM states IDLE, IND_PTR, ACCESS and DONE.
REQ-012 IDLE, `valid_in` & (`cw_in.mem_read` | `cw_in.mem_write`):
- opcode op_ldi/op_sti -> IND_PTR.
- otherwise -> ACCESS.
- Transition occurs in the same cycle the condition is sampled.
REQ-013 IND_PTR:
- Drive `dmem_read`=1 at `address_in`.
- On `dmem_resp`, latch `dmem_rdata` as the pointer and go to ACCESS.
REQ-014 ACCESS:
- Drive `dmem_read` or `dmem_write` per cw.
- Address = latched pointer if the instruction is indirect, else `address_in`.
- Hold all dmem outputs stable until `dmem_resp`; then latch read data and go to DONE.
REQ-015 DONE SHALL last exactly one cycle and then return to IDLE.
REQ-016 `mem_stall` SHALL be:
- 1 in IND_PTR and ACCESS.
- 1 in IDLE when the REQ-012 condition holds.
- 0 in DONE and otherwise.
REQ-017 Word ops: `dmem_wmask`=2'b11 and `dmem_wdata`=`store_data`; `dmem_address` bit 0 is forced to 0.
REQ-018 Byte ops (op_ldb/op_stb):
- `dmem_wmask`=2'b01 if address[0]=0, else 2'b10.
- `dmem_wdata`={store_data[7:0], store_data[7:0]}.
- Load data = selected byte, zero-extended to 16 bits.
REQ-019 `wb_data` SHALL be the latched load data for a memory read, else `result_in`.
REQ-020 `wb_load_regfile` = `valid_in` & `cw_in.load_regfile` & not `mem_stall`; `wb_load_cc` is defined the same way with `cw_in.load_cc`.
REQ-021 `wb_dr` SHALL equal `dr_in` combinationally.
REQ-022 `mem_br_stall` = `valid_in` & `cw_in.branch_stall`, independent of the FSM.
REQ-023 `dmem_read` and `dmem_write` SHALL never be asserted together, and both SHALL be 0 in IDLE and DONE.
REQ-024 A `dmem_resp` arriving in IDLE or DONE SHALL be ignored.
REQ-025 `valid_in`=0 SHALL never start an access; if it drops mid-access the FSM still completes the outstanding access.

Reset
REQ-026 When `reset`=1 at a clock edge:
- State goes to IDLE, and the pointer and load-data registers go to 16'h0000.
- Next cycle, all dmem outputs, `mem_stall` and the wb_load signals read 0.
REQ-027 Reset asserted mid-access SHALL abandon the access without waiting for `dmem_resp`.

Configuration
REQ-028 Macro MEM_INDIRECT_EN SHALL select indirect handling.
- Defined: LDI/STI perform the two sequential accesses of REQ-012..REQ-014.
- Undefined: IND_PTR is never entered. op_ldi/op_sti perform a single word read at `address_in`, returned on `wb_data` as the pointer for the split ldr/str that the execute stage issues next. `wb_load_regfile` and `wb_load_cc` are forced to 0 for these ops.

Verification
REQ-029 Reset: assert `reset` during ACCESS, with `dmem_resp` never returned -> next cycle state IDLE and `mem_stall`=0, `dmem_read`=0.
REQ-030 LDR: address 16'h1234, `dmem_resp` after 3 cycles with rdata 16'hBEEF -> `mem_stall` high 4 cycles, DONE cycle `wb_data`=16'hBEEF, `wb_load_regfile`=1.
REQ-031 STB: address 16'h2001, `store_data`=16'h00A5 -> `dmem_wmask`=2'b10, `dmem_wdata`=16'hA5A5, `dmem_address`=16'h2000.
REQ-032 LDB: address 16'h3000, rdata 16'h7F80 -> `wb_data`=16'h0080.
REQ-033 LDI with MEM_INDIRECT_EN: address 16'h4000 -> first read at 16'h4000 returns 16'h5002; second read at 16'h5002 returns 16'h0042; `wb_data`=16'h0042.
REQ-034 ADD (no memory op), `result_in`=16'h0007 -> `mem_stall`=0, `dmem_read`=`dmem_write`=0, `wb_data`=16'h0007; spurious `dmem_resp` ignored.
